// File: rtl/psum_column_port.sv
// Column <-> psum buffer endpoint: TX FIFO toward the buffer, RX FIFO (MODE2 only) back to the column.
// Packet = {valid, filter_idx[1:0], psum}; MODE1=0, MODE2=1. Optional macro PSUM_SEQ_CHECK_EN adds seq_err.

// Generic FIFO, registered pointers, head visible combinationally; push when full / pop when empty ignored.
module psum_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; occupancy tracking makes stale entries invisible.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module psum_column_port #(
   parameter int TX_DEPTH       = 4,
   parameter int RX_DEPTH       = 2,
   parameter int CNT_W          = 12,
   parameter int PSUM_DATA_SIZE = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_conv,
   input  logic [1:0]                mode_in,
   input  logic [CNT_W-1:0]          psum_total,
   input  logic                      col_psum_valid,
   input  logic [PSUM_DATA_SIZE-1:0] col_psum,
   input  logic [1:0]                col_filter_idx,
   output logic                      col_psum_ready,
   output logic [PSUM_DATA_SIZE+2:0] psum_tx,
   input  logic                      psum_buffer_ack,
   input  logic [PSUM_DATA_SIZE+2:0] psum_rx,
   output logic                      pe_psum_ack,
   output logic                      acc_valid,
   output logic [PSUM_DATA_SIZE-1:0] acc_psum,
   output logic [1:0]                acc_filter_idx,
   input  logic                      acc_ready,
   output logic                      busy,
`ifdef PSUM_SEQ_CHECK_EN
   output logic                      seq_err,
`endif
   output logic                      done
);
   localparam int DW = PSUM_DATA_SIZE + 2;
   localparam logic [1:0] MODE1 = 2'd0;
   localparam logic [1:0] MODE2 = 2'd1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
   state_t state;
   state_t state_nxt;

   logic [1:0]       mode_q;
   logic [CNT_W-1:0] total_q;
   logic [CNT_W-1:0] tx_sent;
   logic [CNT_W-1:0] rx_got;
   logic             start_ok;
   logic             tx_done;
   logic             rx_done;

   logic             tx_push;
   logic             tx_pop;
   logic             tx_full;
   logic             tx_empty;
   logic             tx_vld;
   logic [DW-1:0]    tx_head;

   logic             rx_active;
   logic             rx_pop;
   logic             rx_full;
   logic             rx_empty;
   logic [DW-1:0]    rx_head;

   assign start_ok = start_conv && (state == IDLE);
   assign tx_done  = (tx_sent == total_q);
   assign rx_done  = (rx_got == total_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_conv) state_nxt = RUN;
         RUN:     if (tx_done && ((mode_q != MODE2) || rx_done)) state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DRAIN);
   end

   // Counters stop at the latched total so a late extra transfer cannot overrun completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= MODE1;
         total_q <= '0;
         tx_sent <= '0;
         rx_got  <= '0;
      end else if (start_ok) begin
         mode_q  <= mode_in;
         total_q <= psum_total;
         tx_sent <= '0;
         rx_got  <= '0;
      end else begin
         if (tx_pop && !tx_done)      tx_sent <= tx_sent + 1'b1;
         if (pe_psum_ack && !rx_done) rx_got  <= rx_got + 1'b1;
      end
   end

   assign col_psum_ready = !tx_full && (state != IDLE);
   assign tx_push        = col_psum_valid && col_psum_ready;
   assign tx_vld         = !tx_empty && (state == RUN);
   assign tx_pop         = tx_vld && psum_buffer_ack;
   assign psum_tx        = tx_vld ? {1'b1, tx_head} : '0;

   psum_fifo #(.W(DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (tx_push),
      .push_dat ({col_filter_idx, col_psum}),
      .pop      (tx_pop),
      .head     (tx_head),
      .full     (tx_full),
      .empty    (tx_empty)
   );

   // The buffer advances its filter pointer on every ack, so ack is strictly qualified by valid.
   assign rx_active   = (state == RUN) && (mode_q == MODE2);
   assign pe_psum_ack = psum_rx[DW] && !rx_full && rx_active;
   assign acc_valid   = !rx_empty;
   assign rx_pop      = acc_valid && acc_ready;
   assign {acc_filter_idx, acc_psum} = acc_valid ? rx_head : '0;

   psum_fifo #(.W(DW), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (pe_psum_ack),
      .push_dat (psum_rx[DW-1:0]),
      .pop      (rx_pop),
      .head     (rx_head),
      .full     (rx_full),
      .empty    (rx_empty)
   );

`ifdef PSUM_SEQ_CHECK_EN
   logic [1:0] exp_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_idx <= 2'd0;
         seq_err <= 1'b0;
      end else if (start_ok) begin
         exp_idx <= 2'd0;
         seq_err <= 1'b0;
      end else if (pe_psum_ack) begin
         exp_idx <= exp_idx + 2'd1;
         if (psum_rx[DW-1 -: 2] != exp_idx) seq_err <= 1'b1;
      end
   end
`endif
endmodule
